// File: rtl/ysyx_22050518_div_iter.sv
// ----------------------------------------------------------------------------
// ysyx_22050518_div_iter
//
// Iterative restoring divider for 64-bit and 32-bit (word) operands, signed or
// unsigned. It produces one quotient bit per clock, so a normal divide takes
// 64 cycles, or 32 in word mode. Divide-by-zero and signed overflow finish
// one cycle after the request is accepted.
//
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset
//   dividend    numerator (only bits [31:0] are used in word mode)
//   divisor     denominator (only bits [31:0] are used in word mode)
//   div_valid   request strobe; sampled only while out_ready is high
//   divw        word operation; results are sign-extended from bit 31
//   div_signed  signed operation
//   flush       abort the current operation and return to IDLE
//   out_ready   high in IDLE and DONE, when a request can be accepted
//   out_valid   high for the single DONE cycle
//   quotient    registered quotient; holds until the next DONE
//   remainder   registered remainder; holds until the next DONE
// ----------------------------------------------------------------------------
module ysyx_22050518_div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        div_valid,
    input  logic        divw,
    input  logic        div_signed,
    input  logic        flush,
    output logic        out_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Iteration state: partial remainder, quotient shift register holding the
    // remaining dividend bits, divisor magnitude and latched mode bits.
    logic [6:0]  cnt;
    logic [63:0] rem;
    logic [63:0] quo;
    logic [63:0] dsr;
    logic        w_r;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] a_mag;
    logic [63:0] b_mag;
    logic [63:0] a_sx;
    logic [63:0] special_q;
    logic [63:0] special_r;

    logic [64:0] rem_sh;
    logic [63:0] diff;
    logic        ge;
    logic [63:0] rem_step;
    logic [63:0] quo_step;
    logic        last;
    logic [63:0] q_raw;
    logic [63:0] q_fix;
    logic [63:0] r_fix;
    logic [63:0] q_final;
    logic [63:0] r_final;

    // Request-side decode. Operands are widened to 64 bits at the effective
    // width (sign- or zero-extended in word mode) so the magnitude logic is
    // shared by both widths. Word magnitudes of -2^31 become 2^31, which still
    // reads correctly in bits [31:0].
    always_comb begin
        a_ext     = dividend;
        b_ext     = divisor;
        a_sx      = dividend;
        special_q = '1;
        special_r = '0;

        if (divw) begin
            a_sx = {{32{dividend[31]}}, dividend[31:0]};
            if (div_signed) begin
                a_ext = {{32{dividend[31]}}, dividend[31:0]};
                b_ext = {{32{divisor[31]}}, divisor[31:0]};
            end else begin
                a_ext = {32'b0, dividend[31:0]};
                b_ext = {32'b0, divisor[31:0]};
            end
        end

        a_neg = div_signed & a_ext[63];
        b_neg = div_signed & b_ext[63];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        if (divw) begin
            div_zero = (divisor[31:0] == 32'h0);
            overflow = div_signed && (dividend[31:0] == 32'h8000_0000)
                                  && (divisor[31:0] == 32'hFFFF_FFFF);
        end else begin
            div_zero = (divisor == 64'h0);
            overflow = div_signed && (dividend == 64'h8000_0000_0000_0000)
                                  && (divisor == 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Divide-by-zero wins over overflow.
        special = div_zero | overflow;
        if (div_zero) begin
            special_q = '1;
            special_r = a_sx;
        end else begin
            special_q = a_sx;
            special_r = '0;
        end
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift it needs 65 bits; when the trial subtraction succeeds
    // the true difference fits in 64 bits, so a 64-bit subtract is enough.
    always_comb begin
        rem_sh   = {rem, quo[63]};
        ge       = (rem_sh >= {1'b0, dsr});
        diff     = rem_sh[63:0] - dsr;
        rem_step = ge ? diff : rem_sh[63:0];
        quo_step = {quo[62:0], ge};
        last     = (cnt == (w_r ? 7'd31 : 7'd63));

        q_raw    = w_r ? {32'b0, quo_step[31:0]} : quo_step;
        q_fix    = neg_q ? -q_raw : q_raw;
        r_fix    = neg_r ? -rem_step : rem_step;
        q_final  = w_r ? {{32{q_fix[31]}}, q_fix[31:0]} : q_fix;
        r_final  = w_r ? {{32{r_fix[31]}}, r_fix[31:0]} : r_fix;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. A request accepted in DONE chains
    // straight into the next operation without an IDLE bubble.
    always_comb begin
        state_next = state;
        out_ready  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;

        case (state)
            IDLE: out_ready = 1'b1;
            DONE: begin
                out_ready = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase

        accept = div_valid & out_ready & ~flush;

        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_next = special ? DONE : BUSY;
                end
                BUSY: begin
                    if (last) state_next = DONE;
                end
                DONE: begin
                    if (accept) state_next = special ? DONE : BUSY;
                    else        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath. Results are written only on the edge that enters DONE, so a
    // flushed or reset-aborted operation never disturbs quotient/remainder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            w_r       <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= divw ? {a_mag[31:0], 32'b0} : a_mag;
            dsr   <= b_mag;
            w_r   <= divw;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) begin
                quotient  <= special_q;
                remainder <= special_r;
            end
        end else if (state == BUSY) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 7'd1;
            if (last) begin
                quotient  <= q_final;
                remainder <= r_final;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_div_iter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050518_div_iter
//
// Directed-vector bench for ysyx_22050518_div_iter. Each vector carries a
// hand-computed quotient, remainder and latency (cycles from the accept edge
// to out_valid). Also exercises flush, back-to-back requests, requests during
// BUSY and reset in the middle of an operation.
// ----------------------------------------------------------------------------
module tb_ysyx_22050518_div_iter;

    logic        clk;
    logic        rst_n;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_valid;
    logic        divw;
    logic        div_signed;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    ysyx_22050518_div_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_valid  (div_valid),
        .divw       (divw),
        .div_signed (div_signed),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            passes++;
        end
    endtask

    // Drive one request (called away from the rising edge), let the next
    // rising edge accept it, then scramble the operands since they are
    // don't-care afterwards.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic w);
        dividend   = a;
        divisor    = b;
        div_signed = s;
        divw       = w;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = 1'($urandom);
        divw       = 1'($urandom);
    endtask

    // Count falling edges until out_valid, bounded. Returns on the falling
    // edge inside the DONE cycle.
    task automatic waitResult(input string tag, input int start_lat,
                              input int exp_lat, input logic [63:0] exp_q,
                              input logic [63:0] exp_r);
        int lat;
        int ready_hi;
        lat      = start_lat;
        ready_hi = 0;
        while (lat <= 200) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (out_ready) ready_hi++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_busy_ready"}, 64'(ready_hi), 64'd0);
        checkOutput({tag, "_q"}, quotient, exp_q);
        checkOutput({tag, "_r"}, remainder, exp_r);
    endtask

    task automatic runDivide(input string tag, input logic [63:0] a,
                             input logic [63:0] b, input logic s,
                             input logic w, input int exp_lat,
                             input logic [63:0] exp_q, input logic [63:0] exp_r);
        @(negedge clk);
        applyStimulus(a, b, s, w);
        waitResult(tag, 0, exp_lat, exp_q, exp_r);
    endtask

    initial begin
        int vcount;

        rst_n      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_valid  = 1'b0;
        divw       = 1'b0;
        div_signed = 1'b0;
        flush      = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 64'(out_ready), 64'd1);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_q", quotient, 64'd0);
        checkOutput("reset_r", remainder, 64'd0);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        runDivide("u64_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 65,
                  64'd14, 64'd2);
        runDivide("sw_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 33,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        runDivide("divzero64", 64'h1234, 64'd0, 1'b0, 1'b0, 1,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        runDivide("ovf64", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  1'b1, 1'b0, 1, 64'h8000_0000_0000_0000, 64'd0);
        runDivide("s64_m100_7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 65,
                  64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE);
        runDivide("uw_garbage", 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007,
                  1'b0, 1'b1, 33, 64'd14, 64'd2);
        runDivide("uw_bit31", 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 33,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        runDivide("divzero_w", 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
                  1'b0, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001);
        runDivide("ovf_w", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                  1'b1, 1'b1, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
        runDivide("u64_wide_rem", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                  1'b0, 1'b0, 65, 64'd1, 64'h7FFF_FFFF_FFFF_FFFE);
        runDivide("u64_hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000,
                  1'b0, 1'b0, 65, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
        runDivide("s64_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 65,
                  64'hFFFF_FFFF_FFFF_FFF2, 64'd2);

        // Flush at c+10: IDLE at c+11, no DONE, results untouched.
        $display("[TB] flush");
        @(negedge clk);
        applyStimulus(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_ready", 64'(out_ready), 64'd1);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        checkOutput("flush_no_done", 64'(vcount), 64'd0);
        checkOutput("flush_q", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
        checkOutput("flush_r", remainder, 64'd2);

        // Second request issued inside the DONE cycle of the first.
        $display("[TB] back-to-back");
        runDivide("b2b_first", 64'd100, 64'd7, 1'b0, 1'b0, 65, 64'd14, 64'd2);
        checkOutput("b2b_done_ready", 64'(out_ready), 64'd1);
        applyStimulus(64'd9, 64'd4, 1'b0, 1'b0);
        waitResult("b2b_second", 0, 65, 64'd2, 64'd1);

        // A request during BUSY must not disturb the running divide.
        $display("[TB] request during busy");
        @(negedge clk);
        applyStimulus(64'd1000, 64'd10, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        dividend  = 64'd9;
        divisor   = 64'd4;
        divw      = 1'b0;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        waitResult("busy_ignore", 5, 65, 64'd100, 64'd0);

        // Reset at c+20; a stray div-by-zero request during BUSY is ignored,
        // and reset wins over flush and div_valid.
        $display("[TB] reset mid-operation");
        @(negedge clk);
        applyStimulus(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        dividend  = 64'd5;
        divisor   = 64'd0;
        divw      = 1'b0;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        checkOutput("busy_req_valid", 64'(out_valid), 64'd0);
        checkOutput("busy_req_ready", 64'(out_ready), 64'd0);
        repeat (14) @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b1;
        div_valid = 1'b1;
        dividend  = 64'd5;
        divisor   = 64'd0;
        @(negedge clk);
        checkOutput("midrst_ready", 64'(out_ready), 64'd1);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_q", quotient, 64'd0);
        checkOutput("midrst_r", remainder, 64'd0);
        rst_n     = 1'b1;
        flush     = 1'b0;
        div_valid = 1'b0;
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        checkOutput("midrst_no_done", 64'(vcount), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050518_div_iter.md
YSYX_22050518_DIV_ITER -- requirements
Module: ysyx_22050518_div_iter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be clk and rst_n.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- dividend  in  64  numerator.
- divisor  in  64  denominator.
- div_valid  in  1  request strobe.
- divw  in  1  32-bit (word) operation.
- div_signed  in  1  signed operation.
- flush  in  1  abort the current operation.
- out_ready  out  1  can accept a request.
- out_valid  out  1  result available.
- quotient  out  64  registered quotient.
- remainder  out  64  registered remainder.
REQ-003 The block SHALL have no parameters; the iteration count N SHALL be 64 when divw=0 and 32 when divw=1.

Function
REQ-004 The block SHALL use the states IDLE, BUSY and DONE.
REQ-005 out_ready SHALL be 1 in IDLE and DONE and 0 in BUSY.
REQ-006 out_valid SHALL be 1 only in DONE.
REQ-007 A request SHALL be accepted on a clock edge where div_valid=1, out_ready=1 and flush=0.
REQ-008 On accept, the block SHALL latch the operands, divw and div_signed.
REQ-009 Operand inputs SHALL be don't-care after the accept edge.
REQ-010 div_valid while in BUSY SHALL be ignored.
REQ-011 Normal path: accept -> BUSY, then one restoring shift-subtract iteration per cycle for N cycles, then -> DONE.
REQ-012 On the normal path, out_valid SHALL rise in cycle c+N+1, where c is the accept cycle.
REQ-013 DONE SHALL last one cycle; it SHALL then return to IDLE, or go to BUSY/DONE if a new request is accepted in that DONE cycle (back-to-back).
REQ-014 quotient and remainder SHALL update only on the transition into DONE.
REQ-015 quotient and remainder SHALL hold their values in IDLE and BUSY until the next DONE.
REQ-016 Word mode SHALL use only operand bits [31:0]; the 32-bit quotient and remainder SHALL be sign-extended to 64 bits (for unsigned as well as signed operations).
REQ-017 Signed mode SHALL divide operand magnitudes, then apply the sign rule:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-018 Unsigned mode SHALL treat operands as unsigned.
REQ-019 Divide by zero (divisor at the effective width = 0) SHALL go accept -> DONE in one cycle, with quotient = all ones (sign-extended in word mode) and remainder = the effective dividend (sign-extended in word mode).
REQ-020 Signed overflow SHALL go accept -> DONE in one cycle, with quotient = dividend and remainder = 0.
REQ-021 Signed overflow SHALL be defined as dividend = most-negative at the effective width (0x8000_0000_0000_0000, or 0x8000_0000 in word mode) and divisor = -1.
REQ-022 Divide by zero SHALL take priority over signed overflow.
REQ-023 flush=1 SHALL force the next state to IDLE from any state, with no transition into DONE.
REQ-024 A flushed operation SHALL leave quotient and remainder at their previous values.
REQ-025 flush SHALL take priority over div_valid when both are asserted in the same cycle.
REQ-026 Internal datapath width SHALL be at most 129 bits (partial remainder plus quotient shift register) plus a 7-bit iteration counter.
REQ-027 The block SHALL use no combinational divider and no multi-cycle path.

Reset
REQ-028 With rst_n=0 at a clock edge, the state SHALL become IDLE, the counter 0, and quotient = remainder = 0.
REQ-029 After reset, out_ready SHALL be 1 and out_valid SHALL be 0.
REQ-030 Reset SHALL override flush and div_valid.
REQ-031 Reset asserted mid-operation (BUSY) SHALL abort the operation with no DONE.

Verification
REQ-032 The bench SHALL cover unsigned 64-bit division: dividend=100, divisor=7, signed=0, w=0 -> out_valid at cycle c+65, quotient=14, remainder=2, out_ready=0 during cycles c+1..c+64.
REQ-033 The bench SHALL cover signed word division: dividend=0x...FFFF_FFF9 (-7 in [31:0]), divisor=2, signed=1, w=1 -> out_valid at c+33, quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-034 The bench SHALL cover divide by zero: dividend=0x1234, divisor=0, signed=0, w=0 -> out_valid at c+1, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
REQ-035 The bench SHALL cover signed overflow: dividend=0x8000_0000_0000_0000, divisor=0xFFFF_FFFF_FFFF_FFFF, signed=1 -> out_valid at c+1, quotient=0x8000_0000_0000_0000, remainder=0.
REQ-036 The bench SHALL cover flush and back-to-back requests:
- Step 1: accept 100/7, assert flush at c+10 -> IDLE at c+11, out_valid never rises, quotient/remainder unchanged.
- Step 2: request 9/4 during the DONE cycle -> accepted without an IDLE bubble; result quotient=2, remainder=1.
REQ-037 The bench SHALL cover reset mid-operation: rst_n=0 at c+20 of a 64-bit divide -> next cycle out_ready=1, out_valid=0, quotient=remainder=0; div_valid asserted during BUSY is ignored.
